// File: rtl/mem_lsu.sv
// mem_lsu: multi-cycle load/store stage between EX and WB.
// Issues byte-enabled requests over a ce/ack handshake, stalls until ack or timeout,
// and aligns/extends load data. Non-memory ops pass pc+4 or the ALU result through.
// Build option: define LSU_MISALIGN_TRAP_EN to trap misaligned H/W/D accesses;
// by default the low address bits below the access size are cleared instead.
module mem_lsu #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned PC_WIDTH       = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                memread,
    input  logic                memwrite,
    input  logic [2:0]          funct3,
    input  logic [XLEN-1:0]     alu_result,
    input  logic [XLEN-1:0]     read_data2,
    input  logic [PC_WIDTH-1:0] pcplus4,
    input  logic                getpcplus4,
    output logic                data_ce_o,
    output logic                data_we_o,
    output logic [XLEN/8-1:0]   data_be_o,
    output logic [XLEN-1:0]     data_addr_o,
    output logic [XLEN-1:0]     data_o,
    input  logic [XLEN-1:0]     data_i,
    input  logic                data_ack_i,
    output logic                stall_o,
    output logic [XLEN-1:0]     wb_data,
    output logic                wb_valid,
    output logic                err_o
);

    localparam int unsigned NB   = XLEN / 8;
    localparam int unsigned OFFW = $clog2(NB);
    localparam int unsigned CW   = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e state_q, state_d;

    logic [XLEN-1:OFFW] addr_hi_q;
    logic [OFFW-1:0]    off_q;
    logic [2:0]         funct3_q;
    logic               we_q;
    logic [NB-1:0]      be_q;
    logic [XLEN-1:0]    wdata_q;
    logic [CW-1:0]      cnt_q;
    logic [XLEN-1:0]    res_q;
    logic               err_q;

    logic               mem_op;
    logic               illegal;
    logic               trap;
    logic               timeout;
    int unsigned        nbytes;
    logic [OFFW-1:0]    off_al;
    logic [NB-1:0]      be_new;
    logic [XLEN-1:0]    wdata_new;
    logic [XLEN-1:0]    lane;
    logic [XLEN-1:0]    load_val;

    assign mem_op  = memread | memwrite;
    assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    // Issue-side decode: legality, size-aligned lane offset, byte enables, replicated data.
    always_comb begin
        illegal   = (funct3 == 3'b111) ||
                    ((XLEN == 32) && ((funct3 == 3'b011) || (funct3 == 3'b110)));
        nbytes    = 32'd1 << funct3[1:0];
        // Offset is rounded down to the access size so misaligned accesses stay in-word.
        off_al    = alu_result[OFFW-1:0] & ~OFFW'(nbytes - 1);
        be_new    = '0;
        wdata_new = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            be_new[i]            = (i >= 32'(off_al)) && (i < 32'(off_al) + nbytes);
            wdata_new[8*i +: 8]  = read_data2[8*(i & (nbytes - 1)) +: 8];
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    // Misalignment trap: any address bit below the access size set.
    always_comb begin
        case (funct3[1:0])
            2'd1:    trap = alu_result[0];
            2'd2:    trap = |alu_result[1:0];
            2'd3:    trap = |alu_result[2:0];
            default: trap = 1'b0;
        endcase
    end
`else
    assign trap = 1'b0;
`endif

    // Load alignment and sign/zero extension from the acknowledged word.
    always_comb begin
        lane = data_i >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_val = XLEN'($signed(lane[7:0]));
            3'b001:  load_val = XLEN'($signed(lane[15:0]));
            3'b010:  load_val = XLEN'($signed(lane[31:0]));
            3'b100:  load_val = XLEN'(lane[7:0]);
            3'b101:  load_val = XLEN'(lane[15:0]);
            3'b110:  load_val = XLEN'(lane[31:0]);
            default: load_val = lane;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; illegal or trapped accesses skip the bus entirely.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (mem_op) begin
                    state_d = (illegal || trap) ? StDone : StWait;
                end
            end
            StWait: begin
                if (data_ack_i || timeout) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Request capture, WAIT counter and result/error latching.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_hi_q <= '0;
            off_q     <= '0;
            funct3_q  <= '0;
            we_q      <= 1'b0;
            be_q      <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            res_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (mem_op) begin
                        addr_hi_q <= alu_result[XLEN-1:OFFW];
                        off_q     <= off_al;
                        funct3_q  <= funct3;
                        we_q      <= memwrite;
                        be_q      <= be_new;
                        wdata_q   <= wdata_new;
                        cnt_q     <= '0;
                        res_q     <= '0;
                        err_q     <= illegal || trap;
                    end
                end
                StWait: begin
                    if (data_ack_i) begin
                        res_q <= we_q ? '0 : load_val;
                        err_q <= 1'b0;
                    end else if (timeout) begin
                        res_q <= '0;
                        err_q <= 1'b1;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs: bus from registers in WAIT only; write-back and stall per state.
    always_comb begin
        data_ce_o   = 1'b0;
        data_we_o   = 1'b0;
        data_be_o   = '0;
        data_addr_o = '0;
        data_o      = '0;
        stall_o     = 1'b0;
        wb_data     = '0;
        wb_valid    = 1'b0;
        err_o       = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Suppress pipeline-facing outputs while reset is held.
                if (!rst) begin
                    if (mem_op) begin
                        stall_o = 1'b1;
                    end else begin
                        wb_valid = 1'b1;
                        wb_data  = getpcplus4 ? XLEN'(pcplus4) : alu_result;
                    end
                end
            end
            StWait: begin
                data_ce_o   = 1'b1;
                data_we_o   = we_q;
                data_be_o   = be_q;
                data_addr_o = {addr_hi_q, {OFFW{1'b0}}};
                data_o      = wdata_q;
                stall_o     = 1'b1;
            end
            StDone: begin
                wb_valid = 1'b1;
                wb_data  = res_q;
                err_o    = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu (XLEN=32, TIMEOUT_CYCLES=4): directed steps then
// random accesses checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_mem_lsu;

    localparam int TO = 4;

    logic        clk;
    logic        rst;
    logic        memread;
    logic        memwrite;
    logic [2:0]  funct3;
    logic [31:0] alu_result;
    logic [31:0] read_data2;
    logic [31:0] pcplus4;
    logic        getpcplus4;
    logic        data_ce_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_o;
    logic [31:0] data_i;
    logic        data_ack_i;
    logic        stall_o;
    logic [31:0] wb_data;
    logic        wb_valid;
    logic        err_o;

    int total = 0;
    int bad   = 0;

    mem_lsu #(
        .XLEN           (32),
        .PC_WIDTH       (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .memread     (memread),
        .memwrite    (memwrite),
        .funct3      (funct3),
        .alu_result  (alu_result),
        .read_data2  (read_data2),
        .pcplus4     (pcplus4),
        .getpcplus4  (getpcplus4),
        .data_ce_o   (data_ce_o),
        .data_we_o   (data_we_o),
        .data_be_o   (data_be_o),
        .data_addr_o (data_addr_o),
        .data_o      (data_o),
        .data_i      (data_i),
        .data_ack_i  (data_ack_i),
        .stall_o     (stall_o),
        .wb_data     (wb_data),
        .wb_valid    (wb_valid),
        .err_o       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // ---- reference model ----
    function automatic int unsigned acc_bytes(input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            2'd2:    return 4;
            default: return 8;
        endcase
    endfunction

    function automatic bit is_legal(input logic [2:0] f3);
        return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    endfunction

    function automatic bit traps(input logic [2:0] f3, input logic [31:0] addr);
`ifdef LSU_MISALIGN_TRAP_EN
        return (addr % acc_bytes(f3)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    // Byte index of the accessed lane after rounding down to the access size.
    function automatic int unsigned lane_idx(input logic [2:0] f3, input logic [31:0] addr);
        int unsigned n = acc_bytes(f3);
        return ((addr % 4) / n) * n;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] addr);
        int unsigned m = ((32'd1 << acc_bytes(f3)) - 1) << lane_idx(f3, addr);
        return m[3:0];
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] rs2);
        case (acc_bytes(f3))
            1:       return (rs2 & 32'hFF) * 32'h0101_0101;
            2:       return (rs2 & 32'hFFFF) * 32'h0001_0001;
            default: return rs2;
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        int unsigned    n = acc_bytes(f3);
        longint unsigned v;
        longint unsigned span;
        span = 64'd1 << (8 * n);
        v    = ({32'd0, rdata} >> (8 * lane_idx(f3, addr))) % span;
        if (!f3[2] && n < 4 && v >= span / 2) v = v + 64'h1_0000_0000 - span;
        return v[31:0];
    endfunction

    // One complete access: IDLE presentation, WAIT cycles, DONE, then an IDLE nop with a late ack.
    task automatic access(input string tag, input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] rs2,
                          input logic [31:0] rdata, input int ack_at);
        bit          ok;
        bit          tmo;
        int          waits;
        logic [31:0] want;
        logic [31:0] nop_val;
        ok    = is_legal(f3) && !traps(f3, addr);
        tmo   = ok && !(ack_at >= 1 && ack_at <= TO);
        waits = !ok ? 0 : (tmo ? TO : ack_at);

        @(negedge clk);
        memread = rd; memwrite = wr; funct3 = f3; alu_result = addr; read_data2 = rs2;
        data_ack_i = 1'b0; data_i = $urandom;
        #1;
        chk({tag, " idle stall"}, stall_o, 1);
        chk({tag, " idle ce"}, data_ce_o, 0);
        chk({tag, " idle valid"}, wb_valid, 0);

        for (int k = 1; k <= waits; k++) begin
            @(negedge clk);
            data_ack_i = (k == ack_at);
            data_i     = (k == ack_at) ? rdata : $urandom;
            #1;
            chk({tag, " wait ce"}, data_ce_o, 1);
            chk({tag, " wait stall"}, stall_o, 1);
            if (k == 1) begin
                chk({tag, " addr"}, data_addr_o, addr & 32'hFFFF_FFFC);
                chk({tag, " we"}, data_we_o, wr);
                if (wr) begin
                    chk({tag, " be"}, data_be_o, exp_be(f3, addr));
                    chk({tag, " wdata"}, data_o, exp_wdata(f3, rs2));
                end
            end
        end

        @(negedge clk);
        nop_val = $urandom;
        memread = 1'b0; memwrite = 1'b0; data_ack_i = 1'b0; alu_result = nop_val;
        getpcplus4 = 1'b0;
        #1;
        want = (!ok || tmo || wr) ? 32'd0 : exp_load(f3, addr, rdata);
        chk({tag, " done valid"}, wb_valid, 1);
        chk({tag, " done data"}, wb_data, want);
        chk({tag, " done err"}, err_o, !ok || tmo);
        chk({tag, " done stall"}, stall_o, 0);
        chk({tag, " done ce"}, data_ce_o, 0);

        @(negedge clk);
        data_ack_i = 1'b1;
        #1;
        chk({tag, " after ce"}, data_ce_o, 0);
        chk({tag, " after err"}, err_o, 0);
        chk({tag, " after data"}, wb_data, nop_val);
        @(negedge clk);
        data_ack_i = 1'b0;
        #1;
        chk({tag, " late ack ce"}, data_ce_o, 0);
    endtask

    initial begin
        logic [2:0] f3_pool [8];
        f3_pool = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

        // Reset held for two cycles with a pending load and ack asserted.
        rst = 1'b1; memread = 1'b1; memwrite = 1'b0; funct3 = 3'd2; alu_result = 32'h1000;
        read_data2 = 32'h0; pcplus4 = 32'h0; getpcplus4 = 1'b0; data_i = 32'hDEAD_BEEF;
        data_ack_i = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("rst ce", data_ce_o, 0);
            chk("rst we", data_we_o, 0);
            chk("rst be", data_be_o, 0);
            chk("rst addr", data_addr_o, 0);
            chk("rst dout", data_o, 0);
            chk("rst err", err_o, 0);
            chk("rst valid", wb_valid, 0);
            chk("rst stall", stall_o, 0);
            chk("rst wb", wb_data, 0);
        end

        // Non-memory write-back selection.
        @(negedge clk);
        rst = 1'b0; memread = 1'b0; data_ack_i = 1'b0; alu_result = 32'h1234;
        #1;
        chk("alu wb", wb_data, 32'h1234);
        chk("alu valid", wb_valid, 1);
        chk("alu stall", stall_o, 0);
        getpcplus4 = 1'b1; pcplus4 = 32'h108;
        #1;
        chk("pc4 wb", wb_data, 32'h108);
        getpcplus4 = 1'b0;

        // Directed accesses.
        access("sb", 1'b0, 1'b1, 3'd0, 32'h1003, 32'h0000_00A5, 32'h0, 2);
        access("lb", 1'b1, 1'b0, 3'd0, 32'h1002, 32'h0, 32'h0080_0000, 1);
        access("lbu", 1'b1, 1'b0, 3'd4, 32'h1002, 32'h0, 32'h0080_0000, 1);
        access("lhu", 1'b1, 1'b0, 3'd5, 32'h1002, 32'h0, 32'hBEEF_0000, 3);
        access("lw tmo", 1'b1, 1'b0, 3'd2, 32'h1000, 32'h0, 32'h1111_1111, 0);
        access("lw mis", 1'b1, 1'b0, 3'd2, 32'h1001, 32'h0, 32'hCAFE_F00D, 1);
        access("ld ill", 1'b1, 1'b0, 3'd3, 32'h1000, 32'h0, 32'h0, 1);
        access("both", 1'b1, 1'b1, 3'd1, 32'h2002, 32'h0000_9876, 32'h5555_5555, 1);

        // Reset in the middle of WAIT abandons the access.
        @(negedge clk);
        memread = 1'b1; funct3 = 3'd2; alu_result = 32'h2000;
        @(negedge clk);
        #1;
        chk("midrst wait ce", data_ce_o, 1);
        @(negedge clk);
        rst = 1'b1; data_ack_i = 1'b1;
        @(negedge clk);
        #1;
        chk("midrst ce", data_ce_o, 0);
        chk("midrst err", err_o, 0);
        chk("midrst valid", wb_valid, 0);
        @(negedge clk);
        rst = 1'b0; memread = 1'b0; alu_result = 32'h55;
        #1;
        chk("midrst nop wb", wb_data, 32'h55);
        @(negedge clk);
        #1;
        chk("midrst late ce", data_ce_o, 0);
        chk("midrst late err", err_o, 0);
        data_ack_i = 1'b0;

        // Random accesses.
        for (int n = 0; n < 40; n++) begin
            int          op;
            logic [2:0]  f3;
            op = $urandom_range(0, 2);
            if (op == 0) f3 = f3_pool[$urandom_range(0, 7)];
            else         f3 = f3_pool[$urandom_range(0, 2)];
            if ($urandom_range(0, 9) == 0) f3 = 3'd3;
            access("rnd", op != 1, op != 0, f3, $urandom, $urandom, $urandom,
                   $urandom_range(0, 6));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
